// File: rtl/spi_aes_frame_rx_if.sv
// SPI pin bundle between the AES SPI master and the frame receiver.
`timescale 1ns/1ps
interface spi_aes_frame_rx_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_aes_frame_rx.sv
// SPI mode-0 slave: receives a data block + key frame for the AES engine
// and returns the previously loaded result block on miso.
`timescale 1ns/1ps
module spi_aes_frame_rx #(
    parameter int unsigned Nk = 4
) (
    input  logic                clk_master,
    input  logic                rst,
    spi_aes_frame_rx_if.slave   spi,
    input  logic [127:0]        result_in,
    input  logic                result_load,
    output logic [127:0]        data_out,
    output logic [Nk*32-1:0]    key_out,
    output logic                frame_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned KEY_BITS   = Nk * 32;
    localparam int unsigned FRAME_BITS = 128 + KEY_BITS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic                  sclk_s1, sclk_s2, sclk_s3;
    logic                  cs_s1, cs_s2, cs_s3;
    logic                  mosi_s1, mosi_s2;
    logic [FRAME_BITS-1:0] shift;
    logic [127:0]          tx_reg;
    logic [CNT_W-1:0]      bit_cnt;

    logic sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;

    assign sclk_rise_c =  sclk_s2 & ~sclk_s3;
    assign sclk_fall_c = ~sclk_s2 &  sclk_s3;
    assign cs_fall_c   = ~cs_s2   &  cs_s3;
    assign cs_rise_c   =  cs_s2   & ~cs_s3;

    // Two-flop synchronisers plus a third copy for edge detection
    always_ff @(posedge clk_master) begin
        if (!rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= spi.sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            cs_s1   <= spi.cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= spi.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    always_ff @(posedge clk_master) begin
        if (!rst) begin
            state       <= IDLE;
            shift       <= '0;
            tx_reg      <= '0;
            bit_cnt     <= '0;
            data_out    <= '0;
            key_out     <= '0;
            spi.miso    <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // A load coinciding with the cs_n fall is presented immediately
                    if (result_load) begin
                        tx_reg   <= result_in;
                        spi.miso <= result_in[127];
                    end else begin
                        spi.miso <= tx_reg[127];
                    end
                    if (cs_fall_c) begin
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise_c) begin
                        shift <= {shift[FRAME_BITS-2:0], mosi_s2};
                        if (bit_cnt != CNT_W'(FRAME_BITS + 1))
                            bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    if (sclk_fall_c) begin
                        tx_reg   <= {tx_reg[126:0], 1'b0};
                        spi.miso <= tx_reg[126];
                    end
                    if (cs_rise_c)
                        state <= DONE;
                end
                DONE: begin
                    if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                        data_out    <= shift[FRAME_BITS-1:KEY_BITS];
                        key_out     <= shift[KEY_BITS-1:0];
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_aes_frame_rx.sv
// Randomised bench for spi_aes_frame_rx against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_aes_frame_rx;

    localparam int unsigned NK = 4;
    localparam int unsigned FB = 128 + NK * 32;
    localparam int unsigned H  = 4;

    logic            clk_master = 1'b0;
    logic            rst = 1'b0;
    logic [127:0]    result_in;
    logic            result_load;
    logic [127:0]    data_out;
    logic [NK*32-1:0] key_out;
    logic            frame_valid, frame_err, busy;

    spi_aes_frame_rx_if spi ();

    spi_aes_frame_rx #(.Nk(NK)) dut (
        .clk_master (clk_master),
        .rst        (rst),
        .spi        (spi),
        .result_in  (result_in),
        .result_load(result_load),
        .data_out   (data_out),
        .key_out    (key_out),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk_master = ~clk_master;

    int           n_checks = 0;
    int           n_errs   = 0;
    logic [127:0] m_data, m_key, m_tx;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_result(input logic [127:0] v);
        @(negedge clk_master);
        result_in   = v;
        result_load = 1'b1;
        @(negedge clk_master);
        result_load = 1'b0;
        m_tx = v;
        @(negedge clk_master);
        check("ld_miso", 256'(spi.miso), 256'(v[127]));
    endtask

    // Clock n bits out as a mode-0 master, capturing miso before each rise
    task automatic send_bits(input string tag, input int n, input logic [255:0] payload,
                             input int load_at, output logic [255:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            spi.mosi = (i < 256) ? payload[255-i] : 1'($urandom);
            repeat (H) @(negedge clk_master);
            if (i < 256) cap[255-i] = spi.miso;
            if (i == load_at) begin
                result_in   = '1;
                result_load = 1'b1;
            end
            spi.sclk = 1'b1;
            @(negedge clk_master);
            result_load = 1'b0;
            repeat (H - 1) @(negedge clk_master);
            if (i == 0) check({tag, "_busy"}, 256'(busy), 256'(1));
            spi.sclk = 1'b0;
        end
    endtask

    task automatic watch(output int nv, output int ne, output int both, output int pos);
        nv = 0; ne = 0; both = 0; pos = -1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_master);
            #1;
            if (frame_valid) nv++;
            if (frame_err) ne++;
            if (frame_valid && frame_err) both++;
            if ((frame_valid || frame_err) && pos < 0) pos = c;
        end
    endtask

    task automatic do_frame(input string tag, input int nbits, input logic [255:0] payload,
                            input int load_at, input bit sim_load, input logic [127:0] sim_val);
        logic [255:0] cap, exp_miso, ones;
        logic [127:0] tx0;
        int nv, ne, both, pos;
        bit good;
        ones = '1;
        @(negedge clk_master);
        spi.cs_n = 1'b0;
        if (sim_load) begin
            // Load lands in the same cycle the synchronised cs_n fall is seen
            repeat (2) @(negedge clk_master);
            result_in   = sim_val;
            result_load = 1'b1;
            @(negedge clk_master);
            result_load = 1'b0;
            m_tx = sim_val;
        end
        tx0 = m_tx;
        repeat (H) @(negedge clk_master);
        send_bits(tag, nbits, payload, load_at, cap);
        repeat (H) @(negedge clk_master);
        spi.cs_n = 1'b1;
        watch(nv, ne, both, pos);

        good = (nbits == int'(FB));
        if (good) begin
            m_data = payload[255:128];
            m_key  = payload[127:0];
        end
        m_tx     = (nbits >= 128) ? 128'd0 : (m_tx << nbits);
        exp_miso = {tx0, 128'd0} & ~(ones >> nbits);

        check({tag, "_valid"}, 256'(nv), good ? 256'd1 : 256'd0);
        check({tag, "_err"}, 256'(ne), good ? 256'd0 : 256'd1);
        check({tag, "_both"}, 256'(both), 256'd0);
        check({tag, "_pos"}, 256'(pos), 256'd3);
        check({tag, "_data"}, 256'(data_out), 256'(m_data));
        check({tag, "_key"}, 256'(key_out), 256'(m_key));
        check({tag, "_idle"}, 256'(busy), 256'd0);
        check({tag, "_miso"}, cap, exp_miso);
        check({tag, "_miso_idle"}, 256'(spi.miso), 256'(m_tx[127]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] cap, pl;
        int nv, ne, both, pos, len, sel;
        spi.cs_n = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
        result_in = '0; result_load = 1'b0;
        m_data = '0; m_key = '0; m_tx = '0;
        repeat (3) @(negedge clk_master);
        check("rst_data", 256'(data_out), 256'd0);
        check("rst_key", 256'(key_out), 256'd0);
        check("rst_miso", 256'(spi.miso), 256'd0);
        check("rst_flags", {253'd0, frame_valid, frame_err, busy}, 256'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk_master);

        do_frame("full", 256, {128'h00112233445566778899aabbccddeeff,
                               128'h000102030405060708090a0b0c0d0e0f}, -1, 1'b0, '0);
        do_frame("short200", 200, {8{$urandom}}, -1, 1'b0, '0);
        do_frame("long257", 257, {8{$urandom}}, -1, 1'b0, '0);

        load_result(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        do_frame("miso", 256, {8{$urandom}}, -1, 1'b0, '0);

        load_result({$urandom, $urandom, $urandom, $urandom});
        do_frame("busyload", 256, {8{$urandom}}, 50, 1'b0, '0);
        do_frame("noreload", 256, {8{$urandom}}, -1, 1'b0, '0);

        do_frame("simload", 256, {8{$urandom}}, -1, 1'b1,
                 {$urandom, $urandom, $urandom, $urandom});

        // Reset in the middle of a frame drops it silently
        load_result({$urandom, $urandom, $urandom, $urandom});
        @(negedge clk_master);
        spi.cs_n = 1'b0;
        repeat (H) @(negedge clk_master);
        send_bits("abort", 100, {8{$urandom}}, -1, cap);
        rst = 1'b0;
        spi.cs_n = 1'b1;
        repeat (3) @(negedge clk_master);
        rst = 1'b1;
        m_data = '0; m_key = '0; m_tx = '0;
        watch(nv, ne, both, pos);
        check("abort_pulses", 256'(nv + ne), 256'd0);
        check("abort_data", 256'(data_out), 256'd0);
        check("abort_busy", 256'(busy), 256'd0);
        do_frame("after_rst", 256, {8{$urandom}}, -1, 1'b0, '0);

        for (int k = 0; k < 10; k++) begin
            sel = int'($urandom_range(0, 3));
            if (sel < 2)       len = 256;
            else if (sel == 2) len = int'($urandom_range(1, 255));
            else               len = int'($urandom_range(257, 262));
            if ($urandom_range(0, 1) == 1)
                load_result({$urandom, $urandom, $urandom, $urandom});
            pl = {8{$urandom}};
            do_frame($sformatf("rnd%0d", k), len, pl,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120)) : -1,
                     1'($urandom_range(0, 3) == 0),
                     {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
